// File: rtl/riscv_lsu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_lsu : load/store unit, core access to byte-lane data-memory handshake
// Revision  : 1.0
// ----------------------------------------------------------------------------
module riscv_lsu #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [2:0]        core_size_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [31:0]       core_wd_i,
   output logic [31:0]       core_rd_o,
   output logic              core_stall_o,
   output logic              misalign_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wd_o,
   input  logic [31:0]       mem_rd_i,
   input  logic              mem_ready_i
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t      state;
   logic        legal;
   logic        aligned;
   logic        go;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      legal = 1'b0;
      case (core_size_i)
         3'd0, 3'd1, 3'd2: legal = 1'b1;
         3'd4, 3'd5:       legal = ~core_we_i;
         default:          legal = 1'b0;
      endcase
   end

   always_comb begin
      aligned = 1'b1;
      case (core_size_i)
         3'd1, 3'd5: aligned = ~core_addr_i[0];
         3'd2:       aligned = (core_addr_i[1:0] == 2'b00);
         default:    aligned = 1'b1;
      endcase
   end

   assign go = core_req_i & legal & aligned;

   // A request that goes bad while waiting is treated like an abort.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (go) state <= WAIT;
            WAIT:    if (mem_ready_i || !go) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign misalign_o   = core_req_i & ~(legal & aligned);
   assign mem_req_o    = go;
   assign mem_we_o     = go & core_we_i;
   assign mem_addr_o   = core_addr_i;
   assign core_stall_o = go & ((state == IDLE) | ~mem_ready_i);

   always_comb begin
      mem_be_o = 4'b0000;
      mem_wd_o = 32'h0;
      if (go) begin
         case (core_size_i[1:0])
            2'd0: begin
               mem_be_o = 4'b0001 << core_addr_i[1:0];
               mem_wd_o = {4{core_wd_i[7:0]}};
            end
            2'd1: begin
               mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
               mem_wd_o = {2{core_wd_i[15:0]}};
            end
            default: begin
               mem_be_o = 4'b1111;
               mem_wd_o = core_wd_i;
            end
         endcase
      end
   end

   assign rd_byte = mem_rd_i[{core_addr_i[1:0], 3'b000} +: 8];
   assign rd_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

   always_comb begin
      core_rd_o = 32'h0;
      if (go && !core_we_i) begin
         case (core_size_i)
            3'd0:    core_rd_o = {{24{rd_byte[7]}}, rd_byte};
            3'd4:    core_rd_o = {24'h0, rd_byte};
            3'd1:    core_rd_o = {{16{rd_half[15]}}, rd_half};
            3'd5:    core_rd_o = {16'h0, rd_half};
            default: core_rd_o = mem_rd_i;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_riscv_lsu : directed + randomized bench against an arithmetic reference
// Revision     : 1.0
// ----------------------------------------------------------------------------
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we, ready;
   logic [2:0]  size;
   logic [31:0] addr, wd, mrd;
   logic [31:0] rd_o, wd_o, addr_o;
   logic [3:0]  be_o;
   logic        stall_o, mis_o, mreq_o, mwe_o;

   int tests = 0;
   int fails = 0;
   bit busy  = 1'b0;

   always #5 clk = ~clk;

   riscv_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .core_req_i(req), .core_we_i(we), .core_size_i(size),
      .core_addr_i(addr), .core_wd_i(wd),
      .core_rd_o(rd_o), .core_stall_o(stall_o), .misalign_o(mis_o),
      .mem_req_o(mreq_o), .mem_we_o(mwe_o), .mem_be_o(be_o),
      .mem_addr_o(addr_o), .mem_wd_o(wd_o),
      .mem_rd_i(mrd), .mem_ready_i(ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes_of(input logic [2:0] s);
      return (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit ok_of(input logic w, input logic [2:0] s, input logic [31:0] a);
      bit lg;
      lg = (s <= 3'd2) || (!w && (s == 3'd4 || s == 3'd5));
      return lg && ((a % nbytes_of(s)) == 0);
   endfunction

   // Reference view: the access is "busy" from the cycle after it was issued.
   task automatic check_model(input string tag);
      bit          go;
      int          n, off;
      longint      v, mask;
      logic [31:0] e_be, e_wd, e_rd;
      go   = req && ok_of(we, size, addr);
      n    = nbytes_of(size);
      off  = addr % 4;
      mask = (64'd1 << (8 * n)) - 1;
      e_be = go ? 32'((((1 << n) - 1) << off) & 15) : 32'h0;
      e_wd = 32'h0;
      if (go) begin
         if (n == 1)      e_wd = (wd & 32'hFF) * 32'h01010101;
         else if (n == 2) e_wd = (wd & 32'hFFFF) * 32'h00010001;
         else             e_wd = wd;
      end
      e_rd = 32'h0;
      if (go && !we) begin
         v = (longint'(mrd) >> (8 * off)) & mask;
         if (!size[2] && n < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
         e_rd = 32'(v);
      end
      chk({tag, ".stall"}, {31'h0, stall_o}, {31'h0, go && (!busy || !ready)});
      chk({tag, ".misalign"}, {31'h0, mis_o}, {31'h0, req && !ok_of(we, size, addr)});
      chk({tag, ".mem_req"}, {31'h0, mreq_o}, {31'h0, go});
      chk({tag, ".mem_we"}, {31'h0, mwe_o}, {31'h0, go && we});
      chk({tag, ".be"}, {28'h0, be_o}, e_be);
      chk({tag, ".wd"}, wd_o, e_wd);
      chk({tag, ".rd"}, rd_o, e_rd);
      chk({tag, ".addr"}, addr_o, addr);
   endtask

   task automatic drive(input string tag, input logic r, input logic w, input logic [2:0] s,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] m,
                        input logic rdy);
      req = r; we = w; size = s; addr = a; wd = d; mrd = m; ready = rdy;
      #1;
      check_model(tag);
   endtask

   task automatic tick();
      bit go;
      go = req && ok_of(we, size, addr);
      if (rst)       busy = 1'b0;
      else if (busy) busy = go && !ready;
      else           busy = go;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req = 0; we = 0; size = 0; addr = 32'h0; wd = 0; mrd = 0; ready = 0;
      #12;
      check_model("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Load word
      drive("lw.c1", 1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0);
      chk("lw.c1.stall_lit", {31'h0, stall_o}, 32'h1);
      tick();
      drive("lw.c2", 1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 1);
      chk("lw.c2.rd_lit", rd_o, 32'hDEADBEEF);
      chk("lw.c2.be_lit", {28'h0, be_o}, 32'hF);
      tick();

      // Load byte, signed and unsigned
      drive("lb.c1", 1, 0, 3'd0, 32'h103, 0, 32'h80123456, 0);
      chk("lb.be_lit", {28'h0, be_o}, 32'h8);
      tick();
      drive("lb.c2", 1, 0, 3'd0, 32'h103, 0, 32'h80123456, 1);
      chk("lb.rd_lit", rd_o, 32'hFFFFFF80);
      tick();
      drive("lbu.c1", 1, 0, 3'd4, 32'h103, 0, 32'h80123456, 0);
      tick();
      drive("lbu.c2", 1, 0, 3'd4, 32'h103, 0, 32'h80123456, 1);
      chk("lbu.rd_lit", rd_o, 32'h00000080);
      tick();

      // Halfword store with three wait states
      for (int i = 0; i < 5; i++) begin
         drive("sh", 1, 1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, i == 4);
         chk("sh.stall_lit", {31'h0, stall_o}, {31'h0, i < 4});
         if (i == 0) begin
            chk("sh.be_lit", {28'h0, be_o}, 32'hC);
            chk("sh.wd_lit", wd_o, 32'hABCDABCD);
            chk("sh.we_lit", {31'h0, mwe_o}, 32'h1);
         end
         tick();
      end

      // Misaligned and illegal-size requests
      drive("lw_mis", 1, 0, 3'd2, 32'h101, 0, 32'h0, 0);
      chk("lw_mis.lit", {29'h0, mis_o, mreq_o, stall_o}, 32'h4);
      tick();
      drive("size3", 1, 0, 3'd3, 32'h100, 0, 32'h0, 1);
      chk("size3.lit", {29'h0, mis_o, mreq_o, stall_o}, 32'h4);
      tick();
      drive("after_mis", 1, 0, 3'd2, 32'h100, 0, 32'h0, 1);
      chk("after_mis.stall_lit", {31'h0, stall_o}, 32'h1);
      tick();
      drive("idle", 0, 0, 3'd0, 32'h0, 0, 32'h0, 0);
      tick();

      // Abort while waiting, then a byte store
      drive("ab.c1", 1, 0, 3'd2, 32'h100, 0, 32'h0, 0);
      tick();
      drive("ab.drop", 0, 0, 3'd2, 32'h100, 0, 32'h0, 0);
      tick();
      drive("sb.c1", 1, 1, 3'd0, 32'h10, 32'h55, 32'h0, 1);
      chk("sb.be_lit", {28'h0, be_o}, 32'h1);
      chk("sb.wd_lit", wd_o, 32'h55555555);
      chk("sb.stall_lit", {31'h0, stall_o}, 32'h1);
      tick();
      drive("sb.c2", 1, 1, 3'd0, 32'h10, 32'h55, 32'h0, 1);
      tick();

      // Asynchronous reset in the middle of an access
      drive("rs.c1", 1, 0, 3'd2, 32'h100, 0, 32'h0, 0);
      tick();
      drive("rs.wait", 1, 0, 3'd2, 32'h100, 0, 32'h0, 1);
      rst = 1'b1; busy = 1'b0;
      #1;
      check_model("rs.async");
      chk("rs.async.stall_lit", {31'h0, stall_o}, 32'h1);
      drive("rs.drop", 0, 0, 3'd2, 32'h100, 0, 32'h0, 1);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive("b2b", 1, 0, 3'd2, 32'h100 + 32'(4 * (i / 2)), 0, 32'hCAFE0000 + 32'(i), 1);
         chk("b2b.stall_lit", {31'h0, stall_o}, {31'h0, (i % 2) == 0});
         tick();
      end

      // Randomized traffic: mostly hold the request while an access is open
      for (int c = 0; c < 400; c++) begin
         logic        r, w;
         logic [2:0]  s;
         logic [31:0] a, d;
         if (busy && req && $urandom_range(0, 9) < 8) begin
            r = req; w = we; s = size; a = addr; d = wd;
            if ($urandom_range(0, 19) == 0) r = 1'b0;
         end else begin
            r = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1);
            s = 3'($urandom_range(0, 7));
            a = $urandom();
            d = $urandom();
         end
         drive("rnd", r, w, s, a, d, $urandom(), $urandom_range(0, 2) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
